gate_tt_sequencer: RTL and testbench

- Self-checking controller that sequences a single-output N-input gate (e.g. the switch-level OR_GATE) through all 2^N_IN input combinations.
- Holds each combination for HOLD_CYC clocks, samples the gate output on the last hold cycle and compares it against a runtime expected truth table.
- Reports pass/fail, error count and first failing vector.
- Sits between a bench or BIST host and any gate in the gate library, replacing hand-written per-gate stimulus blocks.

---
 rtl/gate_seq_pkg.sv | 19 +
 rtl/sync_2ff.sv | 35 +++
 rtl/gate_tt_sequencer.sv | 173 +++++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate truth-table sequencer family.
//   state_e   : sequencer FSM states
//   n_vec()   : number of input vectors for an n-input gate (2^n)
//   MAX_N_IN  : widest gate the sequencer supports
package gate_seq_pkg;

  localparam int unsigned MAX_N_IN = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'(1) << n_in;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk, rst_n : clock, async active-low reset (both flops reset to RST_VAL)
//   d          : asynchronous input
//   q          : synchronized output, two clocks behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Plain shift: first stage may go metastable, second stage settles it.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps an N_IN-input gate through all 2^N_IN input vectors, holding each
// for HOLD_CYC clocks, and checks the gate output against a truth table
// latched at start.
// Optional build macro: GATE_SYNC_EN (2-flop synchronizer on gate_out).
//   clk, rst_n     : clock, async active-low reset
//   start          : begin a sweep (accepted in IDLE only)
//   tt_exp         : expected truth table, bit i = output for vector i
//   gate_in        : drives the gate inputs (bit 0 = first input)
//   gate_out       : gate output under test
//   busy           : sweep in progress, through the done cycle
//   done           : one-cycle end-of-sweep pulse
//   pass           : last sweep had no mismatches (held until next start)
//   err_cnt        : mismatch count of current/last sweep
//   first_fail_vec : first mismatching vector, 0 if none
//   fail_seen      : at least one mismatch in current/last sweep
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter  int unsigned N_IN     = 2,
  parameter  int unsigned HOLD_CYC = 10,
  localparam int unsigned N_VEC    = n_vec(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_VEC-1:0] tt_exp,
  output logic [N_IN-1:0]  gate_in,
  input  logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             fail_seen
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);
  localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(N_VEC - 1);

  if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("gate_tt_sequencer: N_IN must be 1..%0d", MAX_N_IN);
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("gate_tt_sequencer: HOLD_CYC must be >= 1");
  end

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_VEC-1:0]  tt_q, tt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              fs_q, fs_d;
  logic              obs_c;
  logic              mismatch_c;

  // Observed gate output: synchronized or direct.
`ifdef GATE_SYNC_EN
  if (HOLD_CYC < 3) begin : g_bad_sync_hold
    $error("gate_tt_sequencer: HOLD_CYC must be >= 3 with GATE_SYNC_EN");
  end
  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (gate_out),
    .q    (obs_c)
  );
`else
  assign obs_c = gate_out;
`endif

  // Case inequality so an X/Z output in simulation counts as a failure.
  assign mismatch_c = (obs_c !== tt_q[vec_q]);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    tt_d    = tt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    fs_d    = fs_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          tt_d    = tt_exp;
          vec_d   = '0;
          hold_d  = HOLD_INIT;
          err_d   = '0;
          ffv_d   = '0;
          fs_d    = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          if (mismatch_c) begin
            err_d = err_q + 1'b1;
            if (!fs_q) begin
              ffv_d = vec_q;
              fs_d  = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d  = vec_q + 1'b1;
            hold_d = HOLD_INIT;
          end
        end
      end
      ST_DONE: begin
        // fs_q already includes the final sample taken on the entry edge.
        done_d  = 1'b1;
        pass_d  = ~fs_q;
        busy_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      fs_q    <= fs_d;
    end
  end

  assign gate_in        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fs_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer with a 2-input behavioural gate model.
module tb_gate_tt_sequencer;

`ifdef GATE_SYNC_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 10;
`endif
  localparam int LAT = 4 * HOLD + 1;

  // Gate model selector
  localparam int M_OR = 0, M_SA0 = 1, M_AND = 2, M_SA1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] tt_exp = 4'b0000;
  logic [1:0] gate_in;
  logic       gate_out;
  logic       busy, done, pass, fail_seen;
  logic [2:0] err_cnt;
  logic [1:0] first_fail_vec;
  int         mode = M_OR;

  int n_checks = 0;
  int n_errors = 0;

  gate_tt_sequencer #(.N_IN(2), .HOLD_CYC(HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .tt_exp        (tt_exp),
    .gate_in       (gate_in),
    .gate_out      (gate_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_fail_vec(first_fail_vec),
    .fail_seen     (fail_seen)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      M_OR:    gate_out = gate_in[0] | gate_in[1];
      M_SA0:   gate_out = 1'b0;
      M_AND:   gate_out = gate_in[0] & gate_in[1];
      default: gate_out = 1'b1;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sweep: returns done latency in edges after the start-accepting edge,
  // count of gate_in steps that were off-schedule, and stray done pulses.
  task automatic run_sweep(input logic [3:0] tt, input int restart_at,
                           input logic [3:0] tt_alt, output int lat,
                           output int gi_bad, output int extra_done);
    int exp_vec;
    lat = -1;
    gi_bad = 0;
    extra_done = 0;
    @(negedge clk);
    start  = 1'b1;
    tt_exp = tt;
    @(posedge clk);
    #1 start = 1'b0;
    if (gate_in !== 2'd0 || busy !== 1'b1) gi_bad++;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(posedge clk);
      #1;
      if (k == restart_at) begin
        start  = 1'b1;
        tt_exp = tt_alt;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
      exp_vec = (k / HOLD > 3) ? 3 : k / HOLD;
      if (lat < 0 && int'(gate_in) != exp_vec) gi_bad++;
      if (done === 1'b1) begin
        if (lat < 0) begin
          lat = k;
          check("busy_in_done", int'(busy), 1);
        end else begin
          extra_done++;
        end
      end
      if (lat > 0 && k == lat + 1) begin
        check("busy_after_done", int'(busy), 0);
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  int lat, gi_bad, xd, dcnt;

  initial begin
    // Reset state
    #1;
    check("rst_outputs", int'({gate_in, busy, done, pass, err_cnt, first_fail_vec, fail_seen}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Good OR
    mode = M_OR;
    run_sweep(4'b1110, -1, 4'b0000, lat, gi_bad, xd);
    check("or_latency", lat, LAT);
    check("or_gate_in_sched", gi_bad, 0);
    check("or_extra_done", xd, 0);
    check("or_pass", int'(pass), 1);
    check("or_err_cnt", int'(err_cnt), 0);
    check("or_fail_seen", int'(fail_seen), 0);
    check("or_ffv", int'(first_fail_vec), 0);
    repeat (5) @(posedge clk);
    #1 check("or_pass_held", int'(pass), 1);

    // OR output stuck at 0
    mode = M_SA0;
    run_sweep(4'b1110, -1, 4'b0000, lat, gi_bad, xd);
    check("sa0_err_cnt", int'(err_cnt), 3);
    check("sa0_ffv", int'(first_fail_vec), 1);
    check("sa0_fail_seen", int'(fail_seen), 1);
    check("sa0_pass", int'(pass), 0);

    // AND against OR table, then against AND table
    mode = M_AND;
    run_sweep(4'b1110, -1, 4'b0000, lat, gi_bad, xd);
    check("and_or_err_cnt", int'(err_cnt), 2);
    check("and_or_ffv", int'(first_fail_vec), 1);
    check("and_or_pass", int'(pass), 0);
    run_sweep(4'b1000, -1, 4'b0000, lat, gi_bad, xd);
    check("and_and_pass", int'(pass), 1);
    check("and_and_err_cnt", int'(err_cnt), 0);

    // Start and new table mid-sweep are ignored
    mode = M_OR;
    run_sweep(4'b1110, (HOLD > 10) ? HOLD : 15 % LAT, 4'b0001, lat, gi_bad, xd);
    check("restart_latency", lat, LAT);
    check("restart_extra_done", xd, 0);
    check("restart_pass", int'(pass), 1);
    check("restart_err_cnt", int'(err_cnt), 0);
    @(negedge clk) tt_exp = 4'b0000;

    // Reset mid-sweep while gate_in == 2
    @(negedge clk);
    start  = 1'b1;
    tt_exp = 4'b1110;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2 * HOLD + 1) @(posedge clk);
    #1 check("pre_rst_gate_in", int'(gate_in), 2);
    #2 rst_n = 1'b0;
    #1 check("midrst_outputs", int'({gate_in, busy, done, pass, err_cnt, first_fail_vec, fail_seen}), 0);
    dcnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1 if (done === 1'b1) dcnt++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (LAT) begin
      @(posedge clk);
      #1 if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    run_sweep(4'b1110, -1, 4'b0000, lat, gi_bad, xd);
    check("postrst_latency", lat, LAT);
    check("postrst_gate_in_sched", gi_bad, 0);
    check("postrst_pass", int'(pass), 1);

    // OR output stuck at 1
    mode = M_SA1;
    run_sweep(4'b1110, -1, 4'b0000, lat, gi_bad, xd);
    check("sa1_err_cnt", int'(err_cnt), 1);
    check("sa1_ffv", int'(first_fail_vec), 0);
    check("sa1_fail_seen", int'(fail_seen), 1);
    check("sa1_pass", int'(pass), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
